// File: rtl/core_pll_supervisor.sv
// Core PLL reset sequencer: pulses the PLL reset, waits for lock with a retry
// budget, qualifies lock stability, then releases the core-domain reset.
module core_pll_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 64,
  parameter int unsigned LOCK_TIMEOUT   = 742500,
  parameter int unsigned LOCK_STABLE    = 7425,
  parameter int unsigned RETRY_MAX      = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       pll_ready,
  output logic       fail,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  localparam logic [31:0] RST_LAST     = 32'(PLL_RST_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE - 1);
  localparam logic [7:0]  RETRY_LIM    = 8'(RETRY_MAX);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        locked_p0_q, locked_p0_d;
  logic        lk_q, lk_d;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic        pll_rst_q, pll_rst_d;
  logic        core_reset_q, core_reset_d;
  logic        pll_ready_q, pll_ready_d;
  logic        fail_q, fail_d;

  // Stage p0/p1: two-flop synchronizer for the asynchronous PLL lock flag
  always_comb begin
    locked_p0_d = locked_in;
    lk_d        = locked_p0_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc32(cnt_q);
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q >= RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lk_q) begin
          state_d = S_STABLE;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = (retry_d >= RETRY_LIM) ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (!lk_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q >= STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = 8'd0;
        end
      end
      S_RUN: begin
        if (!lk_q) begin
          state_d = S_RESET_PLL;
          loss_d  = sat_inc8(loss_q);
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET_PLL;
      end
    endcase

    if (state_d != state_q) cnt_d = 32'd0;

    // Outputs decode the next state so they switch with the state register.
    pll_rst_d    = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    core_reset_d = (state_d != S_RUN);
    pll_ready_d  = (state_d == S_RUN);
    fail_d       = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_p0_q  <= 1'b0;
      lk_q         <= 1'b0;
      state_q      <= S_RESET_PLL;
      cnt_q        <= 32'd0;
      retry_q      <= 8'd0;
      loss_q       <= 8'd0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      pll_ready_q  <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      locked_p0_q  <= locked_p0_d;
      lk_q         <= lk_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      pll_ready_q  <= pll_ready_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_reset  = core_reset_q;
  assign pll_ready   = pll_ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_core_pll_supervisor.sv
// Directed bench for core_pll_supervisor with small timing parameters
// (PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, LOCK_STABLE=8, RETRY_MAX=3).
module tb_core_pll_supervisor;

  logic       refclk;
  logic       rst;
  logic       locked_in;
  logic       pll_rst;
  logic       core_reset;
  logic       pll_ready;
  logic       fail;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  int checks   = 0;
  int failures = 0;

  core_pll_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (16),
    .LOCK_STABLE   (8),
    .RETRY_MAX     (3)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked_in  (locked_in),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .pll_ready  (pll_ready),
    .fail       (fail),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    return (which == 0) ? pll_ready : core_reset;
  endfunction

  // Bounded wait: 0 selects pll_ready, 1 selects core_reset.
  task automatic wait_for(input int which, input logic val, input int max, input string tag);
    for (int n = 0; n < max; n++) begin
      if (sel(which) === val) break;
      tick();
    end
    chk(tag, 32'(sel(which)), 32'(val));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},    32'(pll_rst),    32'd1);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_pll_ready"},  32'(pll_ready),  32'd0);
    chk({tag, "_fail"},       32'(fail),       32'd0);
    chk({tag, "_retry"},      32'(retry_count), 32'd0);
    chk({tag, "_loss"},       32'(loss_count), 32'd0);
  endtask

  initial begin
    logic saw_pll_rst;
    logic saw_release;
    rst       = 1'b1;
    locked_in = 1'b0;
    tick(3);
    chk_reset_vals("reset");

    // 1. Clean bring-up
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_pll_rst_pulse", 32'(pll_rst), (i < 4) ? 32'd1 : 32'd0);
    end
    tick();
    locked_in = 1'b1;
    tick(10);
    chk("t1_core_reset_held", 32'(core_reset), 32'd1);
    tick();
    chk("t1_core_reset_release", 32'(core_reset), 32'd0);
    chk("t1_pll_ready", 32'(pll_ready), 32'd1);
    chk("t1_retry", 32'(retry_count), 32'd0);

    // 2. Lock loss in RUN
    locked_in = 1'b0;
    tick(2);
    chk("t2_core_reset_early", 32'(core_reset), 32'd0);
    tick();
    chk("t2_core_reset_loss", 32'(core_reset), 32'd1);
    chk("t2_loss_count", 32'(loss_count), 32'd1);
    chk("t2_pll_ready", 32'(pll_ready), 32'd0);
    chk("t2_pll_rst_start", 32'(pll_rst), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_pll_rst_pulse", 32'(pll_rst), (i < 4) ? 32'd1 : 32'd0);
    end
    locked_in = 1'b1;
    tick(10);
    chk("t2_relock_held", 32'(core_reset), 32'd1);
    tick();
    chk("t2_relock_release", 32'(core_reset), 32'd0);
    chk("t2_loss_hold", 32'(loss_count), 32'd1);

    // 3. Timeout rounds and FAIL
    locked_in = 1'b0;
    tick(3);
    chk("t3_core_reset_loss", 32'(core_reset), 32'd1);
    chk("t3_loss_count", 32'(loss_count), 32'd2);
    for (int r = 1; r <= 3; r++) begin
      tick(19);
      chk("t3_pre_timeout_retry", 32'(retry_count), 32'(r - 1));
      chk("t3_pre_timeout_pll_rst", 32'(pll_rst), 32'd0);
      tick();
      chk("t3_timeout_retry", 32'(retry_count), 32'(r));
      chk("t3_timeout_pll_rst", 32'(pll_rst), 32'd1);
      chk("t3_fail_flag", 32'(fail), (r == 3) ? 32'd1 : 32'd0);
    end
    locked_in = 1'b1;
    tick(30);
    chk("t3_fail_sticky", 32'(fail), 32'd1);
    chk("t3_fail_pll_rst", 32'(pll_rst), 32'd1);
    chk("t3_fail_core_reset", 32'(core_reset), 32'd1);
    chk("t3_fail_pll_ready", 32'(pll_ready), 32'd0);
    chk("t3_fail_retry", 32'(retry_count), 32'd3);
    rst       = 1'b1;
    locked_in = 1'b0;
    tick();
    chk_reset_vals("t3_rst_from_fail");

    // 4. Stability glitch
    rst = 1'b0;
    tick(5);
    locked_in = 1'b1;
    tick(3);
    tick(5);
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    saw_pll_rst = 1'b0;
    saw_release = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pll_rst) saw_pll_rst = 1'b1;
      if (!core_reset) saw_release = 1'b1;
    end
    chk("t4_no_pll_rst", 32'(saw_pll_rst), 32'd0);
    chk("t4_no_early_release", 32'(saw_release), 32'd0);
    tick();
    chk("t4_release", 32'(core_reset), 32'd0);
    chk("t4_retry", 32'(retry_count), 32'd0);

    // 5. Timeout/lock collision
    locked_in = 1'b0;
    tick(3);
    chk("t5_loss", 32'(core_reset), 32'd1);
    tick(17);
    locked_in = 1'b1;
    tick(3);
    chk("t5_retry_unchanged", 32'(retry_count), 32'd0);
    chk("t5_no_pll_rst", 32'(pll_rst), 32'd0);
    chk("t5_core_reset", 32'(core_reset), 32'd1);
    tick(8);
    chk("t5_release", 32'(core_reset), 32'd0);
    chk("t5_ready", 32'(pll_ready), 32'd1);

    // 6. Reset mid-RUN, then loss counter saturation
    rst = 1'b1;
    tick();
    chk_reset_vals("t6_rst_mid_run");
    rst = 1'b0;
    wait_for(0, 1'b1, 100, "t6_bringup");
    for (int k = 1; k <= 256; k++) begin
      locked_in = 1'b0;
      wait_for(1, 1'b1, 20, "t6_loss_detect");
      locked_in = 1'b1;
      wait_for(0, 1'b1, 60, "t6_relock");
      if (k == 1)   chk("t6_loss_1", 32'(loss_count), 32'd1);
      if (k == 255) chk("t6_loss_255", 32'(loss_count), 32'd255);
    end
    chk("t6_loss_saturated", 32'(loss_count), 32'd255);
    chk("t6_retry_zero", 32'(retry_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_pll_supervisor.md
# core_pll_supervisor

Sequencer on the other side of the core PLL handshake. It drives the PLL `rst` input and consumes the PLL `locked` output. It pulses the PLL reset, waits with a timeout for lock, and qualifies lock as stable. It then releases the core-domain reset and re-arms the PLL on lock loss. It runs on the 74.25 MHz reference clock, ahead of every block clocked by the PLL outputs.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 64: length of the PLL reset pulse, in refclk cycles (≥1).
- `LOCK_TIMEOUT`, 742500: cycles allowed in WAIT_LOCK before a retry (10 ms).
- `LOCK_STABLE`, 7425: consecutive synchronized-locked cycles required before release (100 µs).
- `RETRY_MAX`, 7: timeouts tolerated before FAIL (1..255).

Ports:
- `refclk`  in  1: sole clock (74.25 MHz reference).
- `rst`  in  1: reset, synchronous, active-high.
- `locked_in`  in  1: PLL `locked`, asynchronous to refclk.
- `pll_rst`  out  1: to the PLL `rst` input; registered.
- `core_reset`  out  1: high while PLL clocks are unusable; registered.
- `pll_ready`  out  1: equals `!core_reset && !fail`; registered.
- `fail`  out  1: sticky; set when retries are exhausted.
- `retry_count`  out  8: consecutive lock timeouts since the last RUN entry.
- `loss_count`  out  8: lock losses seen in RUN; saturates at 255.

## Operation
- `locked_in` passes through a 2-flop synchronizer; `lk` is the second flop. The FSM only uses `lk`.
- One cycle counter, 32 bits, shared by all states. It clears on every state transition.
- States:
  - **RESET_PLL**: `pll_rst`=1, `core_reset`=1. After `PLL_RST_CYCLES` cycles in the state → WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0, `core_reset`=1.
    - `lk`=1 → STABLE.
    - If the counter reaches `LOCK_TIMEOUT` with `lk`=0: `retry_count`++.
    - After that increment, if the new value is ≥ `RETRY_MAX` → FAIL, else → RESET_PLL.
  - **STABLE**: `core_reset`=1.
    - `lk`=0 → WAIT_LOCK. The counter clears; `retry_count` is unchanged.
    - `LOCK_STABLE` consecutive `lk`=1 cycles → RUN.
  - **RUN**: `core_reset`=0 and `retry_count` clears to 0 on entry. `lk`=0 → RESET_PLL, `loss_count`++ (saturating), `core_reset`=1 from the next cycle.
  - **FAIL**: `pll_rst`=1, `core_reset`=1, `fail`=1. The only exit is `rst`.
- Outputs are registered decodes of the next state, so each output changes on the same edge as the state register.

## Timing
- Reset values:
  - State RESET_PLL, counter 0.
  - `pll_rst`=1, `core_reset`=1, `pll_ready`=0, `fail`=0, `retry_count`=0, `loss_count`=0.
  - Synchronizer flops 0.
- `rst` has priority over every event in the same cycle, including a mid-sequence RUN or FAIL. The next cycle shows the reset values.
- `pll_rst` width:
  - After `rst` falls, `pll_rst` stays 1 for exactly `PLL_RST_CYCLES` edges, counting the first edge with `rst`=0.
  - Every re-entry to RESET_PLL gives the same pulse width.
- Lock-to-release latency: 2 sync cycles + `LOCK_STABLE` cycles + 1 cycle (the registered output). Release is the `core_reset` falling edge.
- Loss-to-reset latency: 2 sync cycles + 1 cycle from `locked_in` falling to `core_reset` rising.
- Timeout edge cases:
  - Timeout fires on the cycle when the counter equals `LOCK_TIMEOUT`-1 and `lk`=0.
  - If `lk` rises on that same cycle, lock wins: → STABLE, no retry increment.
- A glitch in STABLE (`lk` low for one cycle) restarts qualification from WAIT_LOCK. No PLL reset is issued.
- `loss_count` holds at 255 on further losses; `retry_count` cannot exceed `RETRY_MAX`.

## Test plan
Test parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=16, `LOCK_STABLE`=8, `RETRY_MAX`=3.
1. Clean bring-up: release `rst`, raise `locked_in` 5 cycles later → `pll_rst` high for exactly 4 cycles. `core_reset` falls 11 cycles after `locked_in` rises, `pll_ready`=1, `retry_count`=0.
2. Lock loss in RUN: drop `locked_in` → `core_reset`=1 three cycles later, `loss_count`=1. A new 4-cycle `pll_rst` pulse follows, and re-lock releases again.
3. Timeout and fail: hold `locked_in`=0 → three RESET_PLL/WAIT_LOCK rounds, `retry_count` goes 1, 2, 3. Then `fail`=1, `pll_rst`=1 and stays set until `rst`.
4. Stability glitch: in STABLE at count 5, pulse `locked_in` low for 1 cycle → no `pll_rst` pulse. Qualification restarts; release comes 8 full `lk` cycles after the glitch clears.
5. Timeout/lock collision: raise `locked_in` so `lk` reaches 1 on the timeout cycle → STABLE entered, `retry_count` unchanged.
6. Reset mid-RUN, and saturation:
   - Assert `rst` during RUN → next cycle all outputs are at their reset values.
   - Force 256 lock losses → `loss_count`=255.
